cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_if.sv | 36 +++
 rtl/cpu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Handshake and strobe bundle between the CPU sequencer and its datapath/memory.
// The sequencer sits on the master side; the datapath/bench uses the slave side.
interface cpu_sequencer_if #(
    parameter int unsigned SP_W = 4
) ();
    logic [4:0]      opcode;
    logic            zero_flag;
    logic            mem_ack;
    logic            mem_req;
    logic            mem_we;
    logic [1:0]      addr_sel;
    logic [SP_W-1:0] stack_addr;
    logic            ir_load;
    logic            alu_en;
    logic            reg_we;
    logic            pc_inc;
    logic            pc_load;
    logic [SP_W-1:0] sp;
    logic            stack_fault;
    logic            illegal_op;
    logic [2:0]      state;

    modport master (
        input  opcode, zero_flag, mem_ack,
        output mem_req, mem_we, addr_sel, stack_addr,
        output ir_load, alu_en, reg_we, pc_inc, pc_load,
        output sp, stack_fault, illegal_op, state
    );

    modport slave (
        output opcode, zero_flag, mem_ack,
        input  mem_req, mem_we, addr_sel, stack_addr,
        input  ir_load, alu_en, reg_we, pc_inc, pc_load,
        input  sp, stack_fault, illegal_op, state
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// bounded hardware stack pointer and sticky fault flags.
module cpu_sequencer #(
    parameter int unsigned SP_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    localparam logic [SP_W-1:0] SP_MAX = '1;
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

    state_e          state_q, state_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            stack_fault_q, stack_fault_d;
    logic            illegal_op_q, illegal_op_d;

    logic is_alu, is_jump, is_ld, is_st;
    logic is_be, is_bne, is_push, is_pop;
    logic is_legal, is_mem_cls, is_wr;
    logic push_full, pop_empty;

    logic            mem_req, mem_we;
    logic [1:0]      addr_sel;
    logic            ir_load, alu_en, reg_we, pc_inc, pc_load;
    logic [SP_W-1:0] stack_addr;

    always_comb begin
        is_alu     = (bus.opcode <= 5'd9);
        is_jump    = (bus.opcode == 5'b01110);
        is_ld      = (bus.opcode == 5'b01010);
        is_st      = (bus.opcode == 5'b01100);
        is_be      = (bus.opcode == 5'b10100);
        is_bne     = (bus.opcode == 5'b10101);
        is_push    = (bus.opcode == 5'b10000);
        is_pop     = (bus.opcode == 5'b10010);
        is_legal   = is_alu | is_jump | is_ld | is_st |
                     is_be | is_bne | is_push | is_pop;
        is_mem_cls = is_ld | is_st | is_push | is_pop;
        is_wr      = is_st | is_push;
        push_full  = is_push & (sp_q == SP_MAX);
        pop_empty  = is_pop & (sp_q == '0);
    end

    // POP addresses the topmost occupied slot, everything else the next free one
    always_comb begin
        stack_addr = sp_q;
        if (is_pop && sp_q != '0) begin
            stack_addr = sp_q - SP_ONE;
        end
    end

    always_comb begin
        state_d       = FETCH;
        sp_d          = sp_q;
        stack_fault_d = stack_fault_q;
        illegal_op_d  = illegal_op_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 2'b00;
        ir_load       = 1'b0;
        alu_en        = 1'b0;
        reg_we        = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                state_d = FETCH;
                if (bus.mem_ack) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (push_full || pop_empty || !is_legal) begin
                    pc_inc        = 1'b1;
                    stack_fault_d = stack_fault_q | push_full | pop_empty;
                    illegal_op_d  = illegal_op_q | ~is_legal;
                    state_d       = FETCH;
                end else if (is_mem_cls) begin
                    state_d = MEM;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                unique case (1'b1)
                    is_alu: begin
                        alu_en  = 1'b1;
                        state_d = WB;
                    end
                    is_jump: pc_load = 1'b1;
                    is_be: begin
                        pc_load = bus.zero_flag;
                        pc_inc  = ~bus.zero_flag;
                    end
                    is_bne: begin
                        pc_load = ~bus.zero_flag;
                        pc_inc  = bus.zero_flag;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_wr;
                addr_sel = (is_push | is_pop) ? 2'b10 : 2'b01;
                state_d  = MEM;
                if (bus.mem_ack) begin
                    if (is_wr) begin
                        pc_inc  = 1'b1;
                        state_d = FETCH;
                        if (is_push && sp_q != SP_MAX) begin
                            sp_d = sp_q + SP_ONE;
                        end
                    end else begin
                        state_d = WB;
                        if (is_pop && sp_q != '0) begin
                            sp_d = sp_q - SP_ONE;
                        end
                    end
                end
            end
            WB: begin
                reg_we  = 1'b1;
                pc_inc  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset is asynchronous, so outputs must drop without waiting for a clock
        if (!rst_n) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 2'b00;
            ir_load  = 1'b0;
            alu_en   = 1'b0;
            reg_we   = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            sp_q          <= '0;
            stack_fault_q <= 1'b0;
            illegal_op_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            stack_fault_q <= stack_fault_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.addr_sel    = addr_sel;
    assign bus.stack_addr  = stack_addr;
    assign bus.ir_load     = ir_load;
    assign bus.alu_en      = alu_en;
    assign bus.reg_we      = reg_we;
    assign bus.pc_inc      = pc_inc;
    assign bus.pc_load     = pc_load;
    assign bus.sp          = sp_q;
    assign bus.stack_fault = stack_fault_q;
    assign bus.illegal_op  = illegal_op_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: per-cycle state/strobe
// vectors for each instruction class, stack limits, faults and reset.
module tb_cpu_sequencer;
    localparam int unsigned SP_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_run  = 0;
    int   n_fail = 0;

    cpu_sequencer_if #(.SP_W(SP_W)) bus ();

    cpu_sequencer #(.SP_W(SP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {state[2:0], mem_req, mem_we, addr_sel[1:0], ir_load, alu_en, reg_we, pc_inc, pc_load}
    logic [11:0] obs;
    assign obs = {bus.state, bus.mem_req, bus.mem_we, bus.addr_sel,
                  bus.ir_load, bus.alu_en, bus.reg_we,
                  bus.pc_inc, bus.pc_load};

    function automatic logic [11:0] ev(input logic [2:0] s,
                                       input logic [3:0] m,
                                       input logic [4:0] st);
        return {s, m, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.opcode    = 5'b00000;
        bus.zero_flag = 1'b0;
        bus.mem_ack   = 1'b1;
        #1;
        n_run++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outs: got %h want %h", obs, 12'h000);
        end
        n_run++;
        if ({bus.sp, bus.stack_fault, bus.illegal_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got sp=%0d sf=%b io=%b want 0",
                     bus.sp, bus.stack_fault, bus.illegal_op);
        end
        tick();
        tick();
        n_run++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_held: got %h want %h", obs, 12'h000);
        end
        bus.mem_ack = 1'b0;
        rst_n       = 1'b1;
        #1;
        n_run++;
        if (obs !== ev(3'd0, 4'b1000, 5'b00000)) begin
            n_fail++;
            $display("FAIL reset_first_req: got %h want %h",
                     obs, ev(3'd0, 4'b1000, 5'b00000));
        end
    endtask

    task automatic test_alu();
        logic [11:0] exp_v [5];
        logic [4:0]  ops   [2];
        ops[0] = 5'b00000;
        ops[1] = 5'b01001;
        exp_v[0] = ev(3'd0, 4'b1000, 5'b10000);
        exp_v[1] = ev(3'd1, 4'b0000, 5'b00000);
        exp_v[2] = ev(3'd2, 4'b0000, 5'b01000);
        exp_v[3] = ev(3'd4, 4'b0000, 5'b00110);
        exp_v[4] = ev(3'd0, 4'b1000, 5'b10000);
        for (int k = 0; k < 2; k++) begin
            bus.opcode  = ops[k];
            bus.mem_ack = 1'b1;
            for (int c = 0; c < 5; c++) begin
                if (c > 0) tick();
                #1;
                n_run++;
                if (obs !== exp_v[c]) begin
                    n_fail++;
                    $display("FAIL alu op=%b cyc%0d: got %h want %h",
                             ops[k], c + 1, obs, exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [4:0] ops [5];
        logic       zfs [5];
        logic [4:0] last [5];
        logic [11:0] want;
        ops[0] = 5'b10100; zfs[0] = 1'b1; last[0] = 5'b00001;
        ops[1] = 5'b10100; zfs[1] = 1'b0; last[1] = 5'b00010;
        ops[2] = 5'b10101; zfs[2] = 1'b1; last[2] = 5'b00010;
        ops[3] = 5'b10101; zfs[3] = 1'b0; last[3] = 5'b00001;
        ops[4] = 5'b01110; zfs[4] = 1'b0; last[4] = 5'b00001;
        for (int k = 0; k < 5; k++) begin
            bus.opcode    = ops[k];
            bus.zero_flag = zfs[k];
            bus.mem_ack   = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (c > 0) tick();
                #1;
                case (c)
                    0:       want = ev(3'd0, 4'b1000, 5'b10000);
                    1:       want = ev(3'd1, 4'b0000, 5'b00000);
                    2:       want = ev(3'd2, 4'b0000, last[k]);
                    default: want = ev(3'd0, 4'b1000, 5'b10000);
                endcase
                n_run++;
                if (obs !== want) begin
                    n_fail++;
                    $display("FAIL branch op=%b zf=%b cyc%0d: got %h want %h",
                             ops[k], zfs[k], c + 1, obs, want);
                end
            end
        end
        bus.zero_flag = 1'b0;
    endtask

    task automatic test_mem_wait();
        logic [11:0] exp_v [8];
        logic        ack_v [8];
        exp_v[0] = ev(3'd0, 4'b1000, 5'b10000); ack_v[0] = 1'b1;
        exp_v[1] = ev(3'd1, 4'b0000, 5'b00000); ack_v[1] = 1'b0;
        exp_v[2] = ev(3'd3, 4'b1001, 5'b00000); ack_v[2] = 1'b0;
        exp_v[3] = ev(3'd3, 4'b1001, 5'b00000); ack_v[3] = 1'b0;
        exp_v[4] = ev(3'd3, 4'b1001, 5'b00000); ack_v[4] = 1'b0;
        exp_v[5] = ev(3'd3, 4'b1001, 5'b00000); ack_v[5] = 1'b1;
        exp_v[6] = ev(3'd4, 4'b0000, 5'b00110); ack_v[6] = 1'b1;
        exp_v[7] = ev(3'd0, 4'b1000, 5'b10000); ack_v[7] = 1'b1;
        bus.opcode = 5'b01010;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            bus.mem_ack = ack_v[c];
            #1;
            n_run++;
            if (obs !== exp_v[c]) begin
                n_fail++;
                $display("FAIL ld_wait cyc%0d: got %h want %h",
                         c + 1, obs, exp_v[c]);
            end
        end
        exp_v[0] = ev(3'd0, 4'b1000, 5'b10000);
        exp_v[1] = ev(3'd1, 4'b0000, 5'b00000);
        exp_v[2] = ev(3'd3, 4'b1101, 5'b00010);
        exp_v[3] = ev(3'd0, 4'b1000, 5'b10000);
        bus.opcode  = 5'b01100;
        bus.mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            #1;
            n_run++;
            if (obs !== exp_v[c]) begin
                n_fail++;
                $display("FAIL st cyc%0d: got %h want %h",
                         c + 1, obs, exp_v[c]);
            end
        end
    endtask

    task automatic test_stack();
        logic [11:0] want;
        logic [11:0] exp_v [5];
        n_run++;
        if (bus.sp !== 4'd0) begin
            n_fail++;
            $display("FAIL stack_start: got sp=%0d want 0", bus.sp);
        end
        bus.opcode  = 5'b10000;
        bus.mem_ack = 1'b1;
        want = ev(3'd3, 4'b1110, 5'b00010);
        for (int i = 0; i < 15; i++) begin
            tick();
            tick();
            n_run++;
            if (obs !== want || bus.stack_addr !== 4'(i)) begin
                n_fail++;
                $display("FAIL push%0d: got %h addr=%0d want %h addr=%0d",
                         i, obs, bus.stack_addr, want, i);
            end
            tick();
        end
        n_run++;
        if (bus.sp !== 4'd15) begin
            n_fail++;
            $display("FAIL push_15_sp: got %0d want 15", bus.sp);
        end
        tick();
        n_run++;
        if (obs !== ev(3'd1, 4'b0000, 5'b00010)) begin
            n_fail++;
            $display("FAIL push_full_dec: got %h want %h",
                     obs, ev(3'd1, 4'b0000, 5'b00010));
        end
        tick();
        n_run++;
        if (obs !== ev(3'd0, 4'b1000, 5'b10000) || bus.sp !== 4'd15 ||
            bus.stack_fault !== 1'b1 || bus.illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL push_full_flag: got %h sp=%0d sf=%b io=%b want fetch sp=15 sf=1 io=0",
                     obs, bus.sp, bus.stack_fault, bus.illegal_op);
        end
        exp_v[0] = ev(3'd0, 4'b1000, 5'b10000);
        exp_v[1] = ev(3'd1, 4'b0000, 5'b00000);
        exp_v[2] = ev(3'd3, 4'b1010, 5'b00000);
        exp_v[3] = ev(3'd4, 4'b0000, 5'b00110);
        exp_v[4] = ev(3'd0, 4'b1000, 5'b10000);
        bus.opcode = 5'b10010;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            #1;
            n_run++;
            if (obs !== exp_v[c]) begin
                n_fail++;
                $display("FAIL pop cyc%0d: got %h want %h",
                         c + 1, obs, exp_v[c]);
            end
            if (c == 2) begin
                n_run++;
                if (bus.stack_addr !== 4'd14) begin
                    n_fail++;
                    $display("FAIL pop_addr: got %0d want 14", bus.stack_addr);
                end
            end
        end
        n_run++;
        if (bus.sp !== 4'd14) begin
            n_fail++;
            $display("FAIL pop_sp: got %0d want 14", bus.sp);
        end
    endtask

    task automatic test_pop_empty_illegal();
        logic [4:0] ops [3];
        ops[0] = 5'b10010;
        ops[1] = 5'b11111;
        ops[2] = 5'b10001;
        bus.opcode  = 5'b10010;
        bus.mem_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (obs !== 12'h000 || bus.sp !== 4'd0 || bus.stack_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pulse: got %h sp=%0d sf=%b want 000 sp=0 sf=0",
                     obs, bus.sp, bus.stack_fault);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.opcode = ops[k];
            #1;
            n_run++;
            if (obs !== ev(3'd0, 4'b1000, 5'b10000)) begin
                n_fail++;
                $display("FAIL fault op=%b fetch: got %h want %h",
                         ops[k], obs, ev(3'd0, 4'b1000, 5'b10000));
            end
            tick();
            n_run++;
            if (obs !== ev(3'd1, 4'b0000, 5'b00010)) begin
                n_fail++;
                $display("FAIL fault op=%b dec: got %h want %h",
                         ops[k], obs, ev(3'd1, 4'b0000, 5'b00010));
            end
            tick();
            n_run++;
            if (bus.state !== 3'd0 || bus.sp !== 4'd0 || bus.stack_fault !== 1'b1 ||
                bus.illegal_op !== (k > 0)) begin
                n_fail++;
                $display("FAIL fault op=%b flags: got st=%0d sp=%0d sf=%b io=%b want st=0 sp=0 sf=1 io=%b",
                         ops[k], bus.state, bus.sp, bus.stack_fault,
                         bus.illegal_op, k > 0);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        bus.opcode  = 5'b10000;
        bus.mem_ack = 1'b1;
        tick();
        tick();
        tick();
        n_run++;
        if (bus.sp !== 4'd1 || bus.state !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_push_sp: got sp=%0d st=%0d want sp=1 st=0",
                     bus.sp, bus.state);
        end
        tick();
        bus.mem_ack = 1'b0;
        tick();
        #1;
        n_run++;
        if (obs !== ev(3'd3, 4'b1110, 5'b00000)) begin
            n_fail++;
            $display("FAIL mid_pending: got %h want %h",
                     obs, ev(3'd3, 4'b1110, 5'b00000));
        end
        rst_n = 1'b0;
        #1;
        n_run++;
        if (obs !== 12'h000 || bus.sp !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset_drop: got %h sp=%0d want 000 sp=0",
                     obs, bus.sp);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_run++;
        if (obs !== ev(3'd0, 4'b1000, 5'b00000)) begin
            n_fail++;
            $display("FAIL mid_resume: got %h want %h",
                     obs, ev(3'd0, 4'b1000, 5'b00000));
        end
        tick();
        n_run++;
        if (obs !== ev(3'd0, 4'b1000, 5'b00000)) begin
            n_fail++;
            $display("FAIL mid_fetch_wait: got %h want %h",
                     obs, ev(3'd0, 4'b1000, 5'b00000));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem_wait();
        test_stack();
        test_pop_empty_illegal();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
